// File: rtl/cpu.sv
`default_nettype none
// ============================================================================
//  Module   : cpu
//  Purpose  : Single-cycle simplified MIPS core. It has a 16-word instruction
//             ROM, a 4-entry register file (r0 hard-wired to zero) and a
//             16-bit ALU. One instruction is fetched, executed and written
//             back every clock cycle.
//  Revision : 1.0 - initial release
// ============================================================================
module cpu (
   input  wire logic clock,
   input  wire logic reset
);

   // Opcode encodings
   localparam logic [3:0] c_OP_ADD  = 4'd0;
   localparam logic [3:0] c_OP_SUB  = 4'd1;
   localparam logic [3:0] c_OP_AND  = 4'd2;
   localparam logic [3:0] c_OP_OR   = 4'd3;
   localparam logic [3:0] c_OP_SLT  = 4'd4;
   localparam logic [3:0] c_OP_ADDI = 4'd5;

   // Architectural state; names PC/instruction/ALUOut are probed externally
   logic [15:0] PC;
   logic [15:0] instruction;
   logic [15:0] ALUOut;
   logic [15:0] r_rf [0:3];

   // Decoded instruction fields
   logic [3:0]  w_op;
   logic [1:0]  w_rs;
   logic [1:0]  w_rt;
   logic [1:0]  w_rd;
   logic [15:0] w_imm;
   logic [15:0] w_rs_val;
   logic [15:0] w_rt_val;
   logic [1:0]  w_dest;
   logic        w_wr_en;

   // Instruction ROM lookup; the ROM index wraps every 32 bytes of PC
   always_comb begin
      instruction = 16'h0000;
      case (PC[4:1])
         4'd0:    instruction = 16'h510F;   // addi r1,r0,15
         4'd1:    instruction = 16'h5208;   // addi r2,r0,8
         4'd2:    instruction = 16'h36C0;   // or   r3,r1,r2
         4'd3:    instruction = 16'h2E40;   // and  r1,r3,r2
         4'd4:    instruction = 16'h17C0;   // sub  r3,r1,r3
         4'd5:    instruction = 16'h0680;   // add  r2,r1,r2
         4'd6:    instruction = 16'h4DC0;   // slt  r3,r3,r1
         default: instruction = 16'h0000;   // add  r0,r0,r0 (no effect)
      endcase
   end

   assign w_op  = instruction[15:12];
   assign w_rs  = instruction[11:10];
   assign w_rt  = instruction[9:8];
   assign w_rd  = instruction[7:6];
   assign w_imm = {{8{instruction[7]}}, instruction[7:0]};

   // Read ports: r0 always reads as zero regardless of storage contents
   assign w_rs_val = (w_rs == 2'd0) ? 16'h0000 : r_rf[w_rs];
   assign w_rt_val = (w_rt == 2'd0) ? 16'h0000 : r_rf[w_rt];

   // ALU: result of the current instruction, zero for the unused opcodes
   always_comb begin
      ALUOut = 16'h0000;
      case (w_op)
         c_OP_ADD:  ALUOut = w_rs_val + w_rt_val;
         c_OP_SUB:  ALUOut = w_rs_val - w_rt_val;
         c_OP_AND:  ALUOut = w_rs_val & w_rt_val;
         c_OP_OR:   ALUOut = w_rs_val | w_rt_val;
         c_OP_SLT:  ALUOut = ($signed(w_rs_val) < $signed(w_rt_val)) ? 16'h0001 : 16'h0000;
         c_OP_ADDI: ALUOut = w_rs_val + w_imm;
         default:   ALUOut = 16'h0000;
      endcase
   end

   // Write-back control: addi targets rt, R-type targets rd, others do not write
   assign w_wr_en = (w_op <= c_OP_ADDI);
   assign w_dest  = (w_op == c_OP_ADDI) ? w_rt : w_rd;

   // PC advance and register write-back; reset wins over execution
   always_ff @(posedge clock) begin
      if (!reset) begin
         PC      <= 16'h0000;
         r_rf[0] <= 16'h0000;
         r_rf[1] <= 16'h0000;
         r_rf[2] <= 16'h0000;
         r_rf[3] <= 16'h0000;
      end else begin
         PC <= PC + 16'd2;
         if (w_wr_en && (w_dest != 2'd0)) begin
            r_rf[w_dest] <= ALUOut;
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_cpu.sv
`default_nettype none
// ============================================================================
//  Module   : tb_cpu
//  Purpose  : Directed self-checking bench for the single-cycle cpu core.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_cpu;

   logic clock = 1'b0;
   logic reset = 1'b0;

   int n_checks = 0;
   int n_fail   = 0;

   logic [15:0] exp_pc  [0:6] = '{16'd0, 16'd2, 16'd4, 16'd6, 16'd8, 16'd10, 16'd12};
   logic [15:0] exp_alu [0:6] = '{16'd15, 16'd8, 16'd15, 16'd8, 16'hFFF9, 16'd16, 16'd1};

   // Free-running clock
   always #5 clock = ~clock;

   cpu dut (
      .clock (clock),
      .reset (reset)
   );

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   initial begin
      // Reset held for two edges
      reset = 1'b0;
      repeat (2) @(posedge clock);
      @(negedge clock);
      chk("reset_pc",    dut.PC,          16'd0);
      chk("reset_instr", dut.instruction, 16'h510F);
      chk("reset_alu",   dut.ALUOut,      16'd15);
      chk("reset_r1",    dut.r_rf[1],     16'd0);

      // Program run
      reset = 1'b1;
      for (int i = 0; i < 7; i++) begin
         chk($sformatf("run_pc%0d", i),  dut.PC,     exp_pc[i]);
         chk($sformatf("run_alu%0d", i), dut.ALUOut, exp_alu[i]);
         @(negedge clock);
      end

      // Tail: word 7 (add r0,r0,r0) and final register values
      chk("tail_pc14",  dut.PC,      16'd14);
      chk("tail_alu14", dut.ALUOut,  16'd0);
      chk("tail_r1",    dut.r_rf[1], 16'd8);
      chk("tail_r2",    dut.r_rf[2], 16'd16);
      chk("tail_r3",    dut.r_rf[3], 16'd1);
      @(negedge clock);
      chk("tail_pc16",  dut.PC,      16'd16);
      chk("tail_alu16", dut.ALUOut,  16'd0);

      // Advance to PC = 32 (ROM wrap)
      repeat (8) @(negedge clock);
      chk("wrap_instr", dut.instruction, 16'h510F);
      chk("wrap_r2",    dut.r_rf[2],     16'd16);
      for (int i = 0; i < 5; i++) begin
         chk($sformatf("wrap_pc%0d", i),  dut.PC,     exp_pc[i] + 16'd32);
         chk($sformatf("wrap_alu%0d", i), dut.ALUOut, exp_alu[i]);
         @(negedge clock);
      end

      // Restart cleanly, run to PC = 8, then pulse reset for one edge
      reset = 1'b0;
      @(negedge clock);
      reset = 1'b1;
      repeat (4) @(negedge clock);
      chk("mid_pre_pc",  dut.PC,      16'd8);
      chk("mid_pre_alu", dut.ALUOut,  16'hFFF9);
      chk("mid_pre_r3",  dut.r_rf[3], 16'd15);
      reset = 1'b0;
      @(negedge clock);
      chk("mid_pc",  dut.PC,      16'd0);
      chk("mid_alu", dut.ALUOut,  16'd15);
      chk("mid_r3",  dut.r_rf[3], 16'd0);
      chk("mid_r1",  dut.r_rf[1], 16'd0);
      reset = 1'b1;
      @(negedge clock);
      chk("post_pc",  dut.PC,      16'd2);
      chk("post_alu", dut.ALUOut,  16'd8);
      chk("post_r1",  dut.r_rf[1], 16'd15);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
